mm_spart: RTL and testbench

Memory-mapped serial port (8N1 UART) on the processor's external bus, directly downstream of the core's external memory interface. Consumes the core's address, write data and external read/write strobes; returns read data combinationally in the same cycle, so a load's data is captured in the core's write-back register. Provides one transmit byte buffer, one receive byte buffer, a status register and a programmable baud divisor.

---
 rtl/mm_spart_pkg.sv | 16 +
 rtl/mm_spart_uart_rx.sv | 74 +++++++
 rtl/mm_spart.sv | 146 ++++++++++++++
 tb/tb_mm_spart.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_spart_pkg.sv
// Shared constants and state types for the memory-mapped 8N1 serial port.
package mm_spart_pkg;
  localparam logic [15:0] BASE    = 16'hC000;
  localparam logic [15:0] DIV_RST = 16'd433;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  localparam int ST_TX_READY   = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/mm_spart_uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle done pulse
// asserted on the edge that samples a valid (high) stop bit.
module uart_rx
  import mm_spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic [15:0] div_i,
  output logic [7:0]  byte_o,
  output logic        done_o
);
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [15:0] half_m1;

  // ((div+1)>>1) - 1, clamped at zero for div == 0
  assign half_m1 = (div_i == 16'd0) ? 16'd0 : ((div_i - 16'd1) >> 1);
  assign done_o  = (state_q == RX_STOP) && (cnt_q == 16'd0) && rx_s2_q;
  assign byte_o  = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= RX_START;
            cnt_q   <= half_m1;
          end
        end
        RX_START: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rx_s2_q) begin
            state_q <= RX_IDLE;
          end else begin
            state_q <= RX_DATA;
            cnt_q   <= div_i;
            bit_q   <= 3'd0;
          end
        end
        RX_DATA: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q <= {rx_s2_q, shift_q[7:1]};
            cnt_q   <= div_i;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
          else                state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mm_spart.sv
// Memory-mapped UART: register decode, combinational read port, TX FSM and
// receive buffer with overrun tracking.
module mm_spart
  import mm_spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic        tx,
  input  logic        rx
);
  logic        sel;
  logic [1:0]  off;
  logic        wr_data, wr_div, rd_data, rd_status;
  logic [15:0] div_q, div_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic [7:0]  rx_byte_new;
  logic        rx_done;
  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;
  logic        tx_ready;

  assign sel       = (addr[15:2] == BASE[15:2]);
  assign off       = addr[1:0];
  assign wr_data   = mm_we && sel && (off == OFF_DATA);
  assign wr_div    = mm_we && sel && (off == OFF_DIV);
  assign rd_data   = mm_re && sel && (off == OFF_DATA);
  assign rd_status = mm_re && sel && (off == OFF_STATUS);
  assign tx_ready  = (tx_state_q == TX_IDLE);
  assign tx        = tx_q;

  uart_rx u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .div_i  (div_q),
    .byte_o (rx_byte_new),
    .done_o (rx_done)
  );

  always_comb begin
    rdata = 16'h0000;
    if (mm_re && sel) begin
      case (off)
        OFF_DATA:   rdata = {8'h00, rx_byte_q};
        OFF_STATUS: rdata = {13'd0, rx_overrun_q, rx_valid_q, tx_ready};
        OFF_DIV:    rdata = div_q;
        default:    rdata = 16'h0000;
      endcase
    end
  end

  // A DATA read on the delivery edge frees the buffer, so the new byte lands cleanly
  always_comb begin
    div_d        = wr_div ? wdata : div_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (rd_data)   rx_valid_d   = 1'b0;
    if (rd_status) rx_overrun_d = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rd_data) begin
        rx_byte_d  = rx_byte_new;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= DIV_RST;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // Each bit period reloads the divisor, so a new DIV only applies from the next boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (wr_data) begin
            tx_shift_q <= wdata[7:0];
            tx_q       <= 1'b0;
            tx_cnt_q   <= div_q;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_cnt_q   <= div_q;
            tx_bit_q   <= 3'd0;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else begin
            tx_cnt_q <= div_q;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt_q != 16'd0) tx_cnt_q <= tx_cnt_q - 16'd1;
          else                   tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_spart.sv
// Self-checking bench for mm_spart: bus register access, TX waveform, loopback
// receive with a buffer/overrun reference model, glitch/framing and reset cases.
module tb_mm_spart;
  localparam logic [15:0] A_DATA   = 16'hC000;
  localparam logic [15:0] A_STATUS = 16'hC001;
  localparam logic [15:0] A_DIV    = 16'hC002;
  localparam logic [15:0] A_RSVD   = 16'hC003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  wire  [15:0] rdata;
  wire         tx;
  wire         rx_w = loop_en ? tx : rx_drv;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the programmer-visible state
  int          m_div;
  bit          m_valid, m_ovr;
  logic [7:0]  m_byte;

  mm_spart dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .mm_we (mm_we),
    .mm_re (mm_re),
    .rdata (rdata),
    .tx    (tx),
    .rx    (rx_w)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok %s: %h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; mm_we = 1'b1;
    @(negedge clk);
    mm_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; mm_re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mm_re = 1'b0;
  endtask

  // combinational look without a clock edge, so no read side effect
  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    addr = a; mm_re = 1'b1;
    #1 d = rdata;
    mm_re = 1'b0;
  endtask

  function automatic logic [15:0] exp_status();
    return {13'd0, m_ovr, m_valid, 1'b1};
  endfunction

  task automatic read_data_chk(input string tag);
    logic [15:0] d;
    bus_read(A_DATA, d);
    check(tag, d, {8'h00, m_byte});
    m_valid = 1'b0;
  endtask

  task automatic read_status_chk(input string tag);
    logic [15:0] d;
    bus_read(A_STATUS, d);
    check(tag, d, exp_status());
    m_ovr = 1'b0;
  endtask

  task automatic deliver(input logic [7:0] b);
    if (!m_valid) begin
      m_byte  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic set_div(input int d);
    logic [15:0] r;
    bus_write(A_DIV, d[15:0]);
    m_div = d;
    bus_read(A_DIV, r);
    check("div_rb", r, d[15:0]);
  endtask

  task automatic send_loop(input logic [7:0] b);
    bus_write(A_DATA, {8'hEE, b});
    repeat (12 * (m_div + 1) + 8) @(negedge clk);
    deliver(b);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    int p;
    p = m_div + 1;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (p) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (p) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * p + 4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    logic [9:0]  frame;
    logic [7:0]  b;
    int          op;

    m_div = 433; m_valid = 1'b0; m_ovr = 1'b0; m_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {15'd0, tx}, 16'h0001);
    check("rst_rdata_idle", rdata, 16'h0000);
    rst_n = 1'b1;

    read_status_chk("rst_status");
    bus_read(A_DIV, d);
    check("rst_div", d, 16'd433);
    read_data_chk("rst_data");

    // TX waveform at divisor 3, with an ignored mid-frame store
    set_div(3);
    bus_write(A_DATA, 16'h0055);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      mm_we = 1'b0;
      check($sformatf("tx_bit_c%0d", i), {15'd0, tx}, {15'd0, frame[i / 4]});
      peek(A_STATUS, d);
      check($sformatf("busy_c%0d", i), d, 16'h0000);
      if (i == 5) begin
        addr = A_DATA; wdata = 16'h00FF; mm_we = 1'b1;
      end
      @(negedge clk);
    end
    check("tx_idle_after", {15'd0, tx}, 16'h0001);
    peek(A_STATUS, d);
    check("tx_ready_after", d, 16'h0001);

    // loopback receive
    loop_en = 1'b1;
    set_div(5);
    send_loop(8'hA3);
    peek(A_STATUS, d);
    check("a3_status_peek", d, exp_status());
    read_data_chk("a3_data");
    read_status_chk("a3_status");
    send_loop(8'h11);
    send_loop(8'h22);
    read_status_chk("ovr_status");
    read_data_chk("ovr_data");
    read_status_chk("ovr_cleared");

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        b = 8'($urandom);
        send_loop(b);
      end else if (op == 3) begin
        read_data_chk($sformatf("rnd%0d_data", it));
      end else if (op == 4) begin
        read_status_chk($sformatf("rnd%0d_status", it));
      end else begin
        set_div($urandom_range(3, 9));
      end
    end
    read_status_chk("rnd_final_status");
    read_data_chk("rnd_final_data");

    // glitch and framing error with divisor 7, bench drives rx directly
    loop_en = 1'b0;
    set_div(7);
    read_status_chk("pre_glitch_status");
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (120) @(negedge clk);
    peek(A_STATUS, d);
    check("glitch_status", d, exp_status());
    drive_frame(8'h5C, 1'b0);
    peek(A_STATUS, d);
    check("frame_err_status", d, exp_status());
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    deliver(b);
    peek(A_STATUS, d);
    check("good_after_err_status", d, exp_status());
    read_data_chk("good_after_err_data");

    // reset in the middle of a transmitted frame
    bus_write(A_DATA, 16'h005A);
    repeat (2) @(negedge clk);
    check("mid_frame_tx_low", {15'd0, tx}, 16'h0000);
    #2 rst_n = 1'b0;
    #1 check("async_rst_tx", {15'd0, tx}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    m_div = 433; m_valid = 1'b0; m_ovr = 1'b0; m_byte = 8'h00;
    read_status_chk("post_rst_status");
    bus_read(A_DIV, d);
    check("post_rst_div", d, 16'd433);
    read_data_chk("post_rst_data");
    bus_read(A_RSVD, d);
    check("rsvd_read", d, 16'h0000);
    bus_read(16'h8000, d);
    check("undecoded_read", d, 16'h0000);
    check("post_rst_tx", {15'd0, tx}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
